// File: rtl/stopwatch_digit_chain.sv
// Cascade of NUM_DIGITS per-digit modulo counters with up/down count,
// synchronous clear, parallel load and wrap-or-saturate at the terminal value.
// Digit i occupies Digits[i*DIGIT_W +: DIGIT_W]; digit 0 is least significant.
module stopwatch_digit_chain #(
  parameter int                              NUM_DIGITS = 4,
  parameter int                              DIGIT_W    = 4,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0]   MODULI     = {4'd6, 4'd10, 4'd6, 4'd10},
  parameter int                              WRAP       = 1
) (
  input  logic                            Clock,
  input  logic                            Reset,
  input  logic                            Clear,
  input  logic                            Load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]   LoadValue,
  input  logic                            Enable,
  input  logic                            Down,
  output logic [NUM_DIGITS*DIGIT_W-1:0]   Digits,
  output logic                            Terminal,
  output logic                            Carry
);

  localparam int BUS_W = NUM_DIGITS * DIGIT_W;

  logic [NUM_DIGITS-1:0] at_top;      // digit sits at modulus-1
  logic [NUM_DIGITS-1:0] at_bot;      // digit sits at 0
  logic [NUM_DIGITS-1:0] step;        // digit advances on this Enable tick
  logic [BUS_W-1:0]      next_digits; // chain value after one step
  logic [BUS_W-1:0]      load_clean;  // LoadValue with out-of-range digits zeroed

  // Per-digit terminal detection, ripple step enables, next value and load sanitising.
  always_comb begin
    logic                 ripple;
    logic [DIGIT_W-1:0]   modulus;
    logic [DIGIT_W-1:0]   top;
    logic [DIGIT_W-1:0]   cur;
    logic [DIGIT_W-1:0]   lv;
    // NOTE: every combinational output gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    at_top      = '0;
    at_bot      = '0;
    step        = '0;
    next_digits = Digits;
    load_clean  = '0;
    ripple      = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      modulus   = MODULI[i*DIGIT_W +: DIGIT_W];
      top       = modulus - DIGIT_W'(1);
      cur       = Digits[i*DIGIT_W +: DIGIT_W];
      lv        = LoadValue[i*DIGIT_W +: DIGIT_W];
      at_top[i] = (cur == top);
      at_bot[i] = (cur == '0);
      step[i]   = ripple;
      // A higher digit only moves when every lower digit is at its rollover point.
      ripple    = ripple & (Down ? at_bot[i] : at_top[i]);
      if (step[i]) begin
        if (Down) next_digits[i*DIGIT_W +: DIGIT_W] = at_bot[i] ? top : cur - DIGIT_W'(1);
        else      next_digits[i*DIGIT_W +: DIGIT_W] = at_top[i] ? '0  : cur + DIGIT_W'(1);
      end
      load_clean[i*DIGIT_W +: DIGIT_W] = (lv >= modulus) ? '0 : lv;
    end
  end

  // Terminal depends on the current direction: all-max going up, all-zero going down.
  always_comb begin
    Terminal = Down ? (&at_bot) : (&at_top);
  end

  // Digit register and rollover pulse; priority Reset > Clear > Load > Enable > hold.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (Reset || Clear) begin
      Digits <= '0;
      Carry  <= 1'b0;
    end else if (Load) begin
      Digits <= load_clean;
      Carry  <= 1'b0;
    end else if (Enable) begin
      if (Terminal && (WRAP == 0)) begin
        Carry <= 1'b0;
      end else begin
        Digits <= next_digits;
        Carry  <= Terminal;
      end
    end else begin
      Carry <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stopwatch_digit_chain.sv
// Self-checking bench for stopwatch_digit_chain: a wrapping and a saturating
// instance share stimulus and are compared against an integer-count model.
module tb_stopwatch_digit_chain;

  localparam int          N    = 4;
  localparam int          W    = 4;
  localparam logic [15:0] MODS = {4'd6, 4'd10, 4'd6, 4'd10};

  logic        Clock = 1'b0;
  logic        Reset, Clear, Load, Enable, Down;
  logic [15:0] LoadValue;
  logic [15:0] dig_w, dig_s;
  logic        term_w, term_s, carry_w, carry_s;

  int compared   = 0;
  int mismatched = 0;

  // Model: the chain is a single mixed-radix count in 0..total-1.
  int   cnt_w, cnt_s;
  logic exp_carry_w, exp_carry_s;

  stopwatch_digit_chain #(.NUM_DIGITS(N), .DIGIT_W(W), .MODULI(MODS), .WRAP(1)) dut_wrap (
    .Clock(Clock), .Reset(Reset), .Clear(Clear), .Load(Load), .LoadValue(LoadValue),
    .Enable(Enable), .Down(Down), .Digits(dig_w), .Terminal(term_w), .Carry(carry_w)
  );

  stopwatch_digit_chain #(.NUM_DIGITS(N), .DIGIT_W(W), .MODULI(MODS), .WRAP(0)) dut_sat (
    .Clock(Clock), .Reset(Reset), .Clear(Clear), .Load(Load), .LoadValue(LoadValue),
    .Enable(Enable), .Down(Down), .Digits(dig_s), .Terminal(term_s), .Carry(carry_s)
  );

  always #5 Clock = ~Clock;

  function automatic int mod_of(int i);
    logic [15:0] m;
    m = MODS;
    return int'(m[i*W +: W]);
  endfunction

  function automatic int total();
    int t;
    t = 1;
    for (int i = 0; i < N; i++) t = t * mod_of(i);
    return t;
  endfunction

  function automatic logic [15:0] encode(int n);
    logic [15:0] v;
    int          d;
    v = '0;
    for (int i = 0; i < N; i++) begin
      d = n % mod_of(i);
      n = n / mod_of(i);
      v[i*W +: W] = d[W-1:0];
    end
    return v;
  endfunction

  function automatic int decode(logic [15:0] v);
    int n, weight, d;
    n = 0;
    weight = 1;
    for (int i = 0; i < N; i++) begin
      d = int'(v[i*W +: W]);
      if (d >= mod_of(i)) d = 0;
      n = n + d * weight;
      weight = weight * mod_of(i);
    end
    return n;
  endfunction

  // One clock edge: advance the model from the inputs seen at the edge, then settle.
  task automatic tick();
    int last;
    @(posedge Clock);
    last = total() - 1;
    if (Reset || Clear) begin
      cnt_w = 0; cnt_s = 0; exp_carry_w = 0; exp_carry_s = 0;
    end else if (Load) begin
      cnt_w = decode(LoadValue); cnt_s = cnt_w; exp_carry_w = 0; exp_carry_s = 0;
    end else if (Enable) begin
      exp_carry_s = 0;
      if (Down) begin
        exp_carry_w = (cnt_w == 0);
        cnt_w = (cnt_w == 0) ? last : cnt_w - 1;
        if (cnt_s != 0) cnt_s = cnt_s - 1;
      end else begin
        exp_carry_w = (cnt_w == last);
        cnt_w = (cnt_w == last) ? 0 : cnt_w + 1;
        if (cnt_s != last) cnt_s = cnt_s + 1;
      end
    end else begin
      exp_carry_w = 0; exp_carry_s = 0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    Reset = 0; Clear = 0; Load = 0; Enable = 0; Down = 0; LoadValue = '0;
  endtask

  task automatic do_load(logic [15:0] v);
    Load = 1; LoadValue = v;
    tick();
    Load = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1; Enable = 1;
    for (int c = 0; c < 2; c++) begin
      tick();
      compared++;
      if (dig_w !== 16'h0000) begin mismatched++; $display("FAIL reset_digits cyc%0d: got %h want 0000", c, dig_w); end
      compared++;
      if (carry_w !== 1'b0) begin mismatched++; $display("FAIL reset_carry cyc%0d: got %b want 0", c, carry_w); end
    end
    compared++;
    if (term_w !== 1'b0) begin mismatched++; $display("FAIL reset_terminal_up: got %b want 0", term_w); end
    Down = 1; #1;
    compared++;
    if (term_w !== 1'b1) begin mismatched++; $display("FAIL reset_terminal_down: got %b want 1", term_w); end
    Down = 0; Reset = 0;
    tick();
    compared++;
    if (dig_w !== 16'h0001) begin mismatched++; $display("FAIL first_count: got %h want 0001", dig_w); end
    Enable = 0;
  endtask

  task automatic test_wrap_up();
    idle_inputs();
    do_load(16'h5958);
    compared++;
    if (dig_w !== 16'h5958) begin mismatched++; $display("FAIL load_5958: got %h want 5958", dig_w); end
    Enable = 1;
    tick();
    compared++;
    if (dig_w !== 16'h5959) begin mismatched++; $display("FAIL up_5959: got %h want 5959", dig_w); end
    compared++;
    if (term_w !== 1'b1) begin mismatched++; $display("FAIL term_5959: got %b want 1", term_w); end
    compared++;
    if (carry_w !== 1'b0) begin mismatched++; $display("FAIL carry_5959: got %b want 0", carry_w); end
    tick();
    compared++;
    if (dig_w !== 16'h0000) begin mismatched++; $display("FAIL wrap_0000: got %h want 0000", dig_w); end
    compared++;
    if (carry_w !== 1'b1) begin mismatched++; $display("FAIL wrap_carry: got %b want 1", carry_w); end
    compared++;
    if (dig_s !== 16'h5959) begin mismatched++; $display("FAIL sat_hold_up: got %h want 5959", dig_s); end
    Enable = 0;
    tick();
    compared++;
    if (carry_w !== 1'b0) begin mismatched++; $display("FAIL carry_one_cycle: got %b want 0", carry_w); end
  endtask

  task automatic test_down_borrow();
    idle_inputs();
    do_load(16'h0100);
    Enable = 1; Down = 1;
    tick();
    Enable = 0;
    compared++;
    if (dig_w !== 16'h0059) begin mismatched++; $display("FAIL down_borrow: got %h want 0059", dig_w); end
    compared++;
    if (carry_w !== 1'b0) begin mismatched++; $display("FAIL down_borrow_carry: got %b want 0", carry_w); end
  endtask

  task automatic test_saturate();
    idle_inputs();
    Down = 1;
    do_load(16'h0001);
    Enable = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      compared++;
      if (dig_s !== 16'h0000) begin mismatched++; $display("FAIL sat_digits cyc%0d: got %h want 0000", c, dig_s); end
      compared++;
      if (term_s !== 1'b1) begin mismatched++; $display("FAIL sat_terminal cyc%0d: got %b want 1", c, term_s); end
      compared++;
      if (carry_s !== 1'b0) begin mismatched++; $display("FAIL sat_carry cyc%0d: got %b want 0", c, carry_s); end
    end
    Enable = 0;
  endtask

  task automatic test_load_rules();
    idle_inputs();
    do_load(16'h7A3C);
    compared++;
    if (dig_w !== 16'h0030) begin mismatched++; $display("FAIL load_sanitise: got %h want 0030", dig_w); end
    Enable = 1;
    do_load(16'h1234);
    compared++;
    if (dig_w !== 16'h1234) begin mismatched++; $display("FAIL load_beats_enable: got %h want 1234", dig_w); end
    Enable = 0; Clear = 1;
    do_load(16'h4321);
    Clear = 0;
    compared++;
    if (dig_w !== 16'h0000) begin mismatched++; $display("FAIL clear_beats_load: got %h want 0000", dig_w); end
  endtask

  task automatic test_direction_toggle();
    logic [15:0] want;
    idle_inputs();
    do_load(16'h5959);
    Enable = 1;
    for (int c = 0; c < 6; c++) begin
      Down = (c % 2 == 0);
      tick();
      want = (c % 2 == 0) ? 16'h5958 : 16'h5959;
      compared++;
      if (dig_w !== want) begin mismatched++; $display("FAIL toggle cyc%0d: got %h want %h", c, dig_w, want); end
      compared++;
      if (carry_w !== 1'b0) begin mismatched++; $display("FAIL toggle_carry cyc%0d: got %b want 0", c, carry_w); end
    end
    Enable = 0;
  endtask

  task automatic test_random();
    int last;
    last = total() - 1;
    idle_inputs();
    for (int c = 0; c < 2000; c++) begin
      Reset     = ($urandom_range(0, 99) == 0);
      Clear     = ($urandom_range(0, 79) == 0);
      Load      = ($urandom_range(0, 29) == 0);
      Enable    = ($urandom_range(0, 3) != 0);
      Down      = ($urandom_range(0, 7) == 0) ? ~Down : Down;
      LoadValue = 16'($urandom);
      // Bias loads toward the terminal values so wraps and saturation occur often.
      if ($urandom_range(0, 1) == 1) LoadValue = ($urandom_range(0, 1) == 1) ? 16'h5959 : 16'h0000;
      tick();
      compared++;
      if (dig_w !== encode(cnt_w)) begin mismatched++; $display("FAIL rand_wrap_digits cyc%0d: got %h want %h", c, dig_w, encode(cnt_w)); end
      compared++;
      if (dig_s !== encode(cnt_s)) begin mismatched++; $display("FAIL rand_sat_digits cyc%0d: got %h want %h", c, dig_s, encode(cnt_s)); end
      compared++;
      if (carry_w !== exp_carry_w) begin mismatched++; $display("FAIL rand_wrap_carry cyc%0d: got %b want %b", c, carry_w, exp_carry_w); end
      compared++;
      if (carry_s !== exp_carry_s) begin mismatched++; $display("FAIL rand_sat_carry cyc%0d: got %b want %b", c, carry_s, exp_carry_s); end
      compared++;
      if (term_w !== (Down ? (cnt_w == 0) : (cnt_w == last))) begin
        mismatched++; $display("FAIL rand_wrap_terminal cyc%0d: got %b down %b count %0d", c, term_w, Down, cnt_w);
      end
      compared++;
      if (term_s !== (Down ? (cnt_s == 0) : (cnt_s == last))) begin
        mismatched++; $display("FAIL rand_sat_terminal cyc%0d: got %b down %b count %0d", c, term_s, Down, cnt_s);
      end
    end
    idle_inputs();
  endtask

  initial begin
    cnt_w = 0; cnt_s = 0; exp_carry_w = 0; exp_carry_s = 0;
    idle_inputs();
    test_reset();
    test_wrap_up();
    test_down_borrow();
    test_saturate();
    test_load_rules();
    test_direction_toggle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
